// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared types and constants for the odd-subtraction square root.
// Optional build macro used by sqrt_ctrl: SQRT_ODD_CHECK_EN.
package sqrt_pkg;

  // Sequencer states; encoding is fixed so external probes can decode it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } sqrt_state_t;

  // Default geometry: 8-bit radicand, 4-bit root, 5-bit odd counter.
  localparam int SQRT_DATA_W = 8;
  localparam int SQRT_ROOT_W = 4;
  localparam int SQRT_ODD_W  = 5;

  // The root must cover half the radicand bits, and the odd counter one
  // bit more than the root so 2*root+1 never wraps.
  function automatic bit sqrt_widths_ok(input int data_w, input int root_w,
                                        input int odd_w);
    return (data_w == 2 * root_w) && (odd_w == root_w + 1);
  endfunction

  localparam bit SQRT_WIDTHS_OK = sqrt_widths_ok(SQRT_DATA_W, SQRT_ROOT_W, SQRT_ODD_W);

endpackage

// File: rtl/sqrt_ctrl.sv
// sqrt_ctrl: sequencing FSM for integer square root by subtracting the odd
// numbers 1, 3, 5, ... from the radicand. Drives an external odd counter
// (odd_inc / odd_clr) and reads its value back on odd_num.
// Optional build macro: SQRT_ODD_CHECK_EN adds a sticky odd_err output that
// flags any CHECK cycle where odd_num differs from 2*root+1.
module sqrt_ctrl
  import sqrt_pkg::*;
#(
  parameter int DATA_W = SQRT_DATA_W,
  parameter int ROOT_W = SQRT_ROOT_W,
  parameter int ODD_W  = SQRT_ODD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] radicand,
  input  logic [ODD_W-1:0]  odd_num,
  output logic              odd_inc,
  output logic              odd_clr,
  output logic              busy,
  output logic              done,
  output logic [ROOT_W-1:0] root,
  output logic [DATA_W-1:0] rem
`ifdef SQRT_ODD_CHECK_EN
  ,
  output logic              odd_err
`endif
);

  // Reject inconsistent geometry at elaboration time.
  if (!SQRT_WIDTHS_OK || !sqrt_widths_ok(DATA_W, ROOT_W, ODD_W)) begin : g_bad_widths
    $error("sqrt_ctrl: require DATA_W == 2*ROOT_W and ODD_W == ROOT_W+1");
  end

  sqrt_state_t       state_reg, state_next;
  logic [DATA_W-1:0] rem_reg, rem_next;
  logic [ROOT_W-1:0] root_reg, root_next;
  logic [DATA_W-1:0] odd_ext;
  logic              rem_ge_odd;

  // Odd value widened to the remainder width for compare and subtract.
  assign odd_ext    = {{(DATA_W - ODD_W){1'b0}}, odd_num};
  assign rem_ge_odd = (rem_reg >= odd_ext);

  // State, remainder and root registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      root_reg  <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      root_reg  <= root_next;
    end
  end

  // Next-state, datapath update and state-decoded strobes.
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    root_next  = root_reg;
    odd_inc    = 1'b0;
    odd_clr    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          rem_next   = radicand;
          root_next  = '0;
          state_next = INIT;
        end
      end
      INIT: begin
        // Counter returns to 1 before the first CHECK compare.
        odd_clr    = 1'b1;
        busy       = 1'b1;
        state_next = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        // Subtract only when it cannot underflow; otherwise the root is final.
        if (rem_ge_odd) begin
          rem_next  = rem_reg - odd_ext;
          root_next = root_reg + ROOT_W'(1);
          odd_inc   = 1'b1;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign root = root_reg;
  assign rem  = rem_reg;

`ifdef SQRT_ODD_CHECK_EN
  logic odd_err_reg;

  // Sticky flag: the counter must always present 2*root+1 while checking.
  always_ff @(posedge clk) begin
    if (rst) begin
      odd_err_reg <= 1'b0;
    end else if ((state_reg == CHECK) && (odd_num != {root_reg, 1'b1})) begin
      odd_err_reg <= 1'b1;
    end
  end

  assign odd_err = odd_err_reg;
`endif

endmodule

// File: tb/tb_sqrt_ctrl.sv
// tb_sqrt_ctrl: self-checking bench for sqrt_ctrl with a behavioural odd
// counter alongside and an arithmetic reference for root/remainder/latency.
module tb_sqrt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] radicand;
  logic [4:0] odd_num;
  logic [4:0] odd_cnt;
  logic       odd_inc, odd_clr, busy, done;
  logic [3:0] root;
  logic [7:0] rem;
  logic       odd_force = 1'b0;
`ifdef SQRT_ODD_CHECK_EN
  logic       odd_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Odd counter: clears to 1, steps by 2.
  always @(posedge clk) begin
    if (rst || odd_clr) odd_cnt <= 5'd1;
    else if (odd_inc)   odd_cnt <= odd_cnt + 5'd2;
  end

  assign odd_num = odd_force ? 5'd4 : odd_cnt;

  sqrt_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .radicand (radicand),
    .odd_num  (odd_num),
    .odd_inc  (odd_inc),
    .odd_clr  (odd_clr),
    .busy     (busy),
    .done     (done),
    .root     (root),
    .rem      (rem)
`ifdef SQRT_ODD_CHECK_EN
    ,
    .odd_err  (odd_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: largest r with r*r <= n, remainder n - r*r.
  function automatic void ref_sqrt(input int n, output int r, output int rm);
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    rm = n - r * r;
  endfunction

  // One operation from IDLE; with noise, start and radicand are wiggled
  // while the operation runs and must have no effect.
  task automatic run_op(input int n, input bit noise);
    int er, erem, cyc, incs, clrs, bad_excl, bad_busy, bad_seq;
    ref_sqrt(n, er, erem);
    incs = 0; clrs = 0; bad_excl = 0; bad_busy = 0; bad_seq = 0;
    @(negedge clk);
    start    = 1'b1;
    radicand = n[7:0];
    @(posedge clk);
    for (cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(posedge clk);
      @(negedge clk);
      if (noise) begin
        start    = 1'b1;
        radicand = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (!busy) bad_busy++;
      if (odd_clr) clrs++;
      if (odd_inc && odd_clr) bad_excl++;
      if (odd_inc) begin
        incs++;
        if (int'(odd_num) != 2 * incs - 1) bad_seq++;
      end
    end
    start = 1'b0;
    chk("latency", cyc, er + 2);
    chk("root", root, er);
    chk("rem", rem, erem);
    chk("inc_count", incs, er);
    chk("clr_count", clrs, 1);
    chk("inc_clr_excl", bad_excl, 0);
    chk("busy_during_op", bad_busy, 0);
    chk("odd_sequence", bad_seq, 0);
    chk("busy_at_done", busy, 0);
    chk("odd_final", odd_num, 2 * er + 1);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("root_held", root, er);
    chk("rem_held", rem, erem);
    $display("op N=%0d noise=%0d root=%0d rem=%0d cycles=%0d", n, noise, root, rem, cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int ccount;
    rst      = 1'b1;
    start    = 1'b0;
    radicand = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_root", root, 0);
    chk("rst_rem", rem, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_inc", odd_inc, 0);
    chk("rst_clr", odd_clr, 0);
`ifdef SQRT_ODD_CHECK_EN
    chk("rst_odd_err", odd_err, 0);
`endif
    rst = 1'b0;

    // Directed cases.
    run_op(16, 1'b0);
    run_op(0, 1'b0);
    run_op(255, 1'b0);
    run_op(50, 1'b1);
    run_op(9, 1'b0);

    // Reset on the fifth CHECK cycle of N=200.
    @(negedge clk);
    start    = 1'b1;
    radicand = 8'd200;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    ccount = 0;
    for (int i = 0; i < 20 && ccount < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy && !odd_clr) ccount++;
    end
    chk("reached_check5", ccount, 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_root", root, 0);
    chk("abort_rem", rem, 0);
    chk("abort_done", done, 0);
    chk("abort_inc", odd_inc, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    run_op(200, 1'b0);
    $display("reset-abort sequence complete, N=200 rerun root=%0d rem=%0d", root, rem);

    // Full sweep, with start noise on some operations.
    for (int n = 0; n < 256; n++) begin
      run_op(n, (n % 7) == 3);
`ifdef SQRT_ODD_CHECK_EN
      chk("odd_err_clean", odd_err, 0);
`endif
    end

    // Random operands and random noise.
    for (int i = 0; i < 16; i++) begin
      run_op(int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
    end

`ifdef SQRT_ODD_CHECK_EN
    // Corrupt the counter value during CHECK: N=10 with odd_num=4.
    odd_force = 1'b1;
    @(negedge clk);
    start    = 1'b1;
    radicand = 8'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("forced_done", done, 1);
    chk("odd_err_set", odd_err, 1);
    odd_force = 1'b0;
    run_op(25, 1'b0);
    chk("odd_err_sticky", odd_err, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("odd_err_cleared", odd_err, 0);
    rst = 1'b0;
    $display("odd check sequence complete");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sqrt_ctrl.md
Name: sqrt_ctrl

Overview:
- Sequencing FSM for integer square root by successive odd-integer subtraction.
- Drives the existing 5-bit odd-integer counter (1, 3, 5, ...) through `odd_inc` and `odd_clr`, and reads its `curr_num` value back on `odd_num`.
- Holds the remainder and root registers.
- Sits between the top-level start/result interface and the odd counter; `sqrt_top` instantiates both side by side.

Parameters:
- DATA_W, 8, radicand width; must equal 2*ROOT_W.
- ROOT_W, 4, root width.
- ODD_W, 5, odd-counter width; must equal ROOT_W+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- radicand  in  DATA_W  operand N; latched on an accepted start.
- odd_num  in  ODD_W  current odd value from the counter.
- odd_inc  out  1  counter increment (+2) strobe.
- odd_clr  out  1  counter clear to 1.
- busy  out  1  high in INIT and CHECK.
- done  out  1  one-cycle completion pulse.
- root  out  ROOT_W  floor(sqrt(N)); held until the next accepted start.
- rem  out  DATA_W  N - root^2; held until the next accepted start.

Behaviour:
- Reset:
  - State goes to IDLE.
  - root=0, rem=0, done=0, busy=0, odd_inc=0, odd_clr=0.
  - The odd counter is reset by the same rst at top level.
- States: IDLE, INIT, CHECK, DONE.
- IDLE:
  - start=1 → rem<=radicand, root<=0, go to INIT.
  - start=0 → stay.
- INIT, one cycle:
  - odd_clr=1 (decoded from state).
  - The counter returns to 1 before the next edge.
  - Go to CHECK.
- CHECK, one iteration per cycle:
  - Compare rem against odd_num, zero-extended to DATA_W.
  - If rem >= odd_num: rem<=rem-odd_num, root<=root+1, odd_inc=1, stay in CHECK.
  - Otherwise: odd_inc=0, go to DONE.
- DONE, one cycle: done=1, busy=0, go to IDLE.
- Latency:
  - Start accepted at edge E0 → done is high in the cycle after edge E(root+2).
  - N=0 gives 2 cycles; N=255 gives 17 cycles.
- Width and range rules:
  - For N ≤ 2^DATA_W-1: root ≤ 2^ROOT_W-1 and odd_num ≤ 2^ODD_W-1.
  - Neither register wraps.
  - Subtraction is unsigned and only performed when rem >= odd_num, so there is no underflow.
- odd_inc and odd_clr are mutually exclusive and never high outside CHECK and INIT respectively.
- start while busy or in DONE: ignored, no queuing; radicand changes are ignored after latch.
- start held high continuously: a new operation begins on every return to IDLE (one idle cycle between operations).
- rst mid-operation: abort to IDLE next edge, outputs cleared, no done pulse.

Optional Feature:
- Macro: SQRT_ODD_CHECK_EN.
- Defined:
  - Extra output port `odd_err` (1 bit, sticky).
  - In every CHECK cycle, if odd_num != 2*root+1, set odd_err=1.
  - Cleared only by rst; it does not alter sequencing.
- Undefined:
  - No port, no logic.
  - Behaviour otherwise identical.

Decomposition:
- Package sqrt_pkg holds:
  - the state enumeration, encoded IDLE=0, INIT=1, CHECK=2, DONE=3;
  - the default DATA_W/ROOT_W/ODD_W constants;
  - a width-consistency check constant.
- No sub-module inside sqrt_ctrl: the FSM, the comparator/subtractor and the root counter stay in one file.
- The odd counter remains a separate block, wired alongside in sqrt_top.

Test Plan:
- N=16, start pulse:
  - done after 6 cycles, root=4, rem=0.
  - odd_inc high exactly 4 cycles; odd_num sequence 1,3,5,7,9.
- N=0:
  - done after 2 cycles, root=0, rem=0.
  - odd_inc never high; odd_clr high 1 cycle.
- N=255:
  - done after 17 cycles, root=15, rem=30.
  - odd_num ends at 31, no wrap.
- N=50 then, while busy, start with N=9:
  - second start ignored; root=7, rem=1.
  - The next start in IDLE with N=9 gives root=3, rem=0.
- N=200, rst asserted on the 5th CHECK cycle:
  - next cycle IDLE, root=0, rem=0, busy=0, no done.
  - A subsequent N=200 gives root=14, rem=4.
- SQRT_ODD_CHECK_EN build:
  - Force odd_num=4 during CHECK → odd_err=1 and stays 1.
  - A clean build with a normal counter keeps odd_err=0 across N=0..255.
